// File: rtl/incrementer_register.sv
// rtl/incrementer_register.sv - operand register wrapped around a WIDTH-bit incrementer
//
// Holds the incrementer's A operand, accepts CLR / LOAD / INC_N commands over a
// valid/ready handshake and, while running, captures the incrementer result back
// into the register once per clock. It also tracks a sticky wrap flag and a
// sticky result-check flag.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  high when a command can be accepted (IDLE)
//   cmd_op     00 NOP, 01 CLR, 10 LOAD, 11 INC_N
//   cmd_data   LOAD value, or increment count N for INC_N
//   a_out      register value, drives incrementer A
//   z_in       incrementer sum
//   cout_in    incrementer carry out
//   ovf_out    sticky: all-ones -> 0 wrap occurred
//   err_out    sticky: incrementer result did not equal a_out + 1
//   done_out   one-cycle completion pulse
//   busy_out   high while incrementing
module incrementer_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] z_in,
    input  logic             cout_in,
    output logic             ovf_out,
    output logic             err_out,
    output logic             done_out,
    output logic             busy_out
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] remaining;
    logic             ovf_reg;
    logic             err_reg;
    logic             done_reg;
    logic             accept;
    logic             last_pass;
    logic [WIDTH:0]   expected_sum;

    assign accept    = cmd_valid && (state == IDLE);
    assign last_pass = (state == RUN) && (remaining == {{(WIDTH-1){1'b0}}, 1'b1});

    // Widened by one bit so the expected carry is compared along with the sum.
    assign expected_sum = {1'b0, a_reg} + {{WIDTH{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (cmd_op == OP_INC) && (cmd_data != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_pass) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready = 1'b0;
        busy_out  = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            RUN:     busy_out  = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Datapath: operand register, pass counter and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            remaining <= '0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state == RUN) begin
                a_reg     <= z_in;
                ovf_reg   <= ovf_reg | cout_in;
                err_reg   <= err_reg | ({cout_in, z_in} != expected_sum);
                remaining <= remaining - {{(WIDTH-1){1'b0}}, 1'b1};
                if (last_pass) begin
                    done_reg <= 1'b1;
                end
            end else if (accept) begin
                case (cmd_op)
                    OP_CLR: begin
                        a_reg    <= '0;
                        ovf_reg  <= 1'b0;
                        err_reg  <= 1'b0;
                        done_reg <= 1'b1;
                    end
                    OP_LOAD: begin
                        a_reg    <= cmd_data;
                        ovf_reg  <= 1'b0;
                        done_reg <= 1'b1;
                    end
                    OP_INC: begin
                        // N=0 completes immediately; otherwise the count is armed
                        // and the register is left alone until the first pass.
                        if (cmd_data == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            remaining <= cmd_data;
                        end
                    end
                    OP_NOP:  ;
                    default: ;
                endcase
            end
        end
    end

    assign a_out    = a_reg;
    assign ovf_out  = ovf_reg;
    assign err_out  = err_reg;
    assign done_out = done_reg;

endmodule

// File: doc/incrementer_register.md
Name: incrementer_register

Overview:
- Holds the operand register that drives the 4-bit binary incrementer's A input and captures its sum/carry outputs back into that register.
- Provides clear, parallel load and "increment N times" commands over a valid/ready handshake.
- Runs one incrementer pass per clock, keeps a sticky overflow flag, and checks each incrementer result against the expected value.
- Sits directly around the incrementer as its upstream source and downstream sink, as the lab datapath's program-counter/general-register stage.

Parameters:
- WIDTH, 4, register width; must match the incrementer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 NOP, 01 CLR, 10 LOAD, 11 INC_N.
- cmd_data  input  WIDTH  LOAD value, or N for INC_N.
- a_out  output  WIDTH  register value; drives incrementer A.
- z_in  input  WIDTH  incrementer sum (combinational from a_out).
- cout_in  input  1  incrementer carry out.
- ovf_out  output  1  sticky: a wrap from all-ones to 0 occurred.
- err_out  output  1  sticky: incrementer result mismatch detected.
- done_out  output  1  one-cycle pulse on command completion.
- busy_out  output  1  high while in RUN.

Behaviour:
- Reset: on a clk edge with rst_n=0, a_out=0, ovf_out=0, err_out=0, done_out=0, busy_out=0, remaining count=0, state=IDLE. Reset overrides any in-flight INC_N; no done pulse is produced.
- States are IDLE and RUN.
  - cmd_ready = (state==IDLE).
  - busy_out = (state==RUN).
- Accept: a command is accepted on an edge where cmd_valid & cmd_ready. cmd_valid is ignored in RUN; there is no queueing.
- NOP: no state change, no done pulse.
- CLR: at the accept edge, a_out=0, ovf_out=0, err_out=0. done_out=1 for the following cycle. State stays IDLE.
- LOAD: at the accept edge, a_out=cmd_data and ovf_out=0; err_out is unchanged. done_out=1 for the following cycle. State stays IDLE.
- INC_N, N=0: no register change; done_out=1 for the following cycle. State stays IDLE.
- INC_N, N>0: at the accept edge, remaining=N and state goes to RUN; a_out is not yet changed.
- Each RUN edge:
  - a_out <= z_in.
  - ovf_out <= ovf_out | cout_in.
  - remaining <= remaining-1.
  - err_out <= err_out | ({cout_in,z_in} != a_out+1, computed WIDTH+1 bits wide).
- When remaining==1 on a RUN edge, state goes to IDLE and done_out=1 for the next cycle.
- Latency and throughput:
  - INC_N with N>0 takes N RUN edges after the accept edge.
  - done_out is visible after edge N and cmd_ready returns at the same time.
  - The next command can be accepted on edge N+1.
- Back-to-back: a new command accepted while done_out=1 is legal. done_out deasserts on the next edge unless that command itself completes.
- Wrap-around: all-ones + 1 gives a_out=0 and sets ovf_out. ovf_out stays set until CLR, LOAD or reset.
- Arithmetic rules: all register arithmetic is modulo 2^WIDTH; the count N is unsigned.
- Output timing: a_out is registered, so the incrementer input changes only on clk edges. z_in/cout_in must settle within one cycle.
- Reserved behaviour: none; every cmd_op encoding is defined.

Test Plan:
- Reset, then LOAD 4'h3 -> a_out=3, done_out pulses once, ovf_out=0, cmd_ready stays 1.
- LOAD 4'hD, then INC_N N=5 -> cmd_ready low for 5 cycles; a_out goes E,F,0,1,2; ovf_out sets on the F->0 edge; done_out pulses once after the 5th edge; err_out=0.
- INC_N N=0 with a_out=7 -> a_out stays 7, done_out pulses once, busy_out never asserts.
- During RUN of INC_N N=4, hold cmd_valid=1 with CLR -> CLR is ignored until cmd_ready=1, then accepted. Final a_out=0, ovf_out=0.
- Assert rst_n=0 at the 2nd RUN cycle of INC_N N=6 from 4'h1 -> next edge a_out=0, state IDLE, no done pulse, cmd_ready=1.
- Force z_in=a_out (stuck incrementer) during INC_N N=2 -> err_out sets after the 1st RUN edge and stays set through a LOAD; it clears only on CLR or reset.
